sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 8-entry FIFO.
- Adds:
  - configurable width and depth;
  - simultaneous read and write in one cycle;
  - an occupancy count, which gives true full at DEPTH entries;
  - almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a read-valid strobe.
- Sits between producer and consumer blocks in the datapath as general-purpose elastic buffering.

Parameters:
DATA_W, 32, width of write and read data
DEPTH, 8, number of entries; power of 2, >= 2
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a freshly popped word
count  out  ADDR_W+1  occupancy 0..DEPTH, where ADDR_W = clog2(DEPTH)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset values (rst sampled high at an edge):
  - count = 0, pointers = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Memory array is not cleared; its contents are don't-care until written.
  - Reset mid-operation discards all stored data; wr_en and rd_en are ignored in that cycle.
- Handshake:
  - push = wr_en && (!full || pop).
  - pop = rd_en && !empty.
  - wr_en && !push sets overflow. rd_en && !pop sets underflow.
  - Both error flags are cleared only by rst.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
  - Each increments on push or pop respectively.
- Count:
  - +1 on push only, -1 on pop only.
  - Unchanged on push and pop in the same cycle, or on neither.
- Flags are registered and computed from the next count, so they update on the same edge as count. There is no combinational path from wr_en/rd_en to any flag.
- Simultaneous events:
  - Full with wr_en && rd_en: both accepted; count stays DEPTH; no overflow.
  - Empty with wr_en && rd_en: write accepted, read rejected; underflow set; count becomes 1.
- Read latency (default mode):
  - rd_data = mem[rd_ptr] is registered on the pop edge; rd_valid = 1 for exactly the next cycle.
  - rd_data holds its last value when there is no pop.
- Write-to-read latency: a word written at edge N can be popped at edge N+1 and is visible on rd_data after edge N+1.
- Read and write address compares are on ADDR_W bits. Full versus empty is disambiguated by count, not by pointer equality.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data = mem[rd_ptr], combinational from the array; rd_valid = !empty.
  - rd_en while rd_valid consumes the head; the next word appears after that edge.
  - A write into an empty FIFO gives rd_valid = 1 one cycle after the write edge.
- Undefined: default registered-read behaviour as above.
- Flags, count and error semantics are identical in both modes.

Decomposition:
- Shared package fifo_pkg holds:
  - a clog2 constant function;
  - default width and depth constants;
  - a localparam-style helper for the count width (ADDR_W+1).
- Sub-module fifo_mem: simple dual-port register array with DATA_W, DEPTH, a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- The top level holds the pointers, count, flags and read register.

Test Plan (DATA_W=32, DEPTH=8, AF=6, AE=1):
- Reset, then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Write 0x11..0x88 (8 words), then read 8 -> almost_full rises at count=6, full=1 at count=8; reads return 0x11..0x88 in order, rd_valid one cycle after each rd_en; empty=1 after the last pop.
- Fill 8, write 0xDEAD with rd_en low -> overflow=1 and stays; count=8; 0xDEAD never read.
- Fill 8, then assert wr_en && rd_en with 0xAAAA for 10 cycles -> count stays 8, no overflow, output order continues correctly across pointer wrap.
- Empty FIFO, wr_en && rd_en with 0x5 -> underflow=1, count=1, next read returns 0x5; assert rst mid-stream afterwards -> all outputs return to reset values.
- Build with SYNC_FIFO_FWFT_EN: write 0x42 into empty -> next cycle rd_valid=1 and rd_data=0x42 without rd_en; rd_en pops it and empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH, one bit wider than an address.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1,
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int CNT_W     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_nx;
    logic [DATA_W-1:0] mem_rdata;
    logic              push;
    logic              pop;

    assign pop  = rd_en && !empty;
    assign push = wr_en && (!full || pop);

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + CNT_W'(1);
        else if (pop && !push)
            count_nx = count - CNT_W'(1);
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Flags are registered from count_nx so they move with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count        <= count_nx;
            full         <= (count_nx == CNT_W'(DEPTH));
            empty        <= (count_nx == '0);
            almost_full  <= (count_nx >= CNT_W'(AF_THRESH));
            almost_empty <= (count_nx <= CNT_W'(AE_THRESH));
            if (wr_en && !push) overflow  <= 1'b1;
            if (rd_en && !pop)  underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem_rdata;
    assign rd_valid = !empty;
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (pop) rd_data_q <= mem_rdata;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue model.
module tb_sync_fifo_param;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int AE  = 1;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, almost_empty;
    logic          overflow, underflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    sync_fifo_param #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".full"}, 64'(full), 64'(n == DEP));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".afull"}, 64'(almost_full), 64'(n >= AF));
        chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= AE));
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".udf"}, 64'(underflow), 64'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(n != 0));
        if (n != 0) chk({tag, ".rd_data"}, 64'(rd_data), 64'(q[0]));
`else
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rd_valid));
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_rd_data));
`endif
    endtask

    // Called at a negedge: drive, clock, update model, check at next negedge.
    task automatic step(input string tag, input bit r, input bit wr,
                        input logic [DW-1:0] d, input bit rd);
        bit do_pop, do_push;
        rst = r; wr_en = wr; wr_data = d; rd_en = rd;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_rd_data = '0; m_rd_valid = 1'b0;
            m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            do_pop  = rd && (q.size() != 0);
            do_push = wr && ((q.size() != DEP) || do_pop);
            m_rd_valid = do_pop;
            if (do_pop) m_rd_data = q.pop_front();
            if (do_push) q.push_back(d);
            if (wr && !do_push) m_ovf = 1'b1;
            if (rd && !do_pop) m_udf = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < DEP; i++)
            step("fill", 0, 1, base + DW'(i), 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEP + 1; i++) step(tag, 0, 0, '0, 1);
    endtask

    initial begin
        @(negedge clk);
        step("reset", 1, 0, '0, 0);
        step("idle", 0, 0, '0, 0);

        for (int i = 1; i <= 8; i++)
            step("wr_seq", 0, 1, DW'(i * 'h11), 0);
        for (int i = 0; i < 8; i++) step("rd_seq", 0, 0, '0, 1);
        step("rd_seq_idle", 0, 0, '0, 0);

        step("reset2", 1, 0, '0, 0);
        fill(32'h100);
        step("ovf", 0, 1, 32'hDEAD, 0);
        drain("ovf_drain");

        step("reset3", 1, 0, '0, 0);
        fill(32'h200);
        for (int i = 0; i < 10; i++)
            step("full_rw", 0, 1, 32'hAAAA + DW'(i), 1);
        drain("wrap_drain");

        step("reset4", 1, 0, '0, 0);
        step("udf_rw", 0, 1, 32'h5, 1);
        step("udf_rd", 0, 0, '0, 1);
        step("udf_wr", 0, 1, 32'h77, 0);
        step("udf_wr2", 0, 1, 32'h78, 0);
        step("mid_rst", 1, 1, 32'h99, 1);
        step("post_rst", 0, 0, '0, 0);

        step("fwft_wr", 0, 1, 32'h42, 0);
        step("fwft_hold", 0, 0, '0, 0);
        step("fwft_pop", 0, 0, '0, 1);

        for (int i = 0; i < 3000; i++) begin
            bit r, wr, rd;
            int mode;
            mode = (i / 200) % 3;
            r  = ($urandom_range(0, 499) == 0);
            wr = ($urandom_range(0, 99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50)));
            rd = ($urandom_range(0, 99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50)));
            step("rand", r, wr, DW'($urandom), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
